// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT at BASE_ADDR) driving irq.
// Define BUS_TIMER_RELOAD_EN to enable MODE 01 auto-reload; otherwise MODE is hardwired to 00.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

`ifdef BUS_TIMER_RELOAD_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h9;
`endif

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q, irq_d;

  logic [29:0] word_off;
  logic        wr_ctrl, wr_preset;
  logic [3:0]  ctrl_wr;
  logic        reload_mode;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^addr[1:0];

  assign word_off    = addr[31:2] - BASE_ADDR[31:2];
  assign hit         = (word_off < 30'd3);
  assign wr_ctrl     = hit && (|byteen) && (word_off[1:0] == 2'd0);
  assign wr_preset   = hit && (|byteen) && (word_off[1:0] == 2'd1);
  assign ctrl_wr     = byteen[0] ? (wdata[3:0] & CTRL_WMASK) : ctrl_q;
  assign reload_mode = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (word_off[1:0])
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: if (ctrl_q[0]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        if (reload_mode) begin
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clears first so that a same-cycle expiry set takes priority.
    if (wr_ctrl || (state_q == INT && reload_mode)) irq_flag_d = 1'b0;
    if (state_q == CNT && ctrl_q[0] && count_q == 32'd0) irq_flag_d = 1'b1;

    // A CTRL write overrides the one-shot EN clear; unwritten lanes keep the pre-edge value.
    if (wr_ctrl) ctrl_d = ctrl_wr;

    if (wr_preset) begin
      for (int i = 0; i < 4; i++) begin
        if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end

    irq_d = ctrl_d[3] & irq_flag_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
